yuv_word_packer: RTL and testbench

Downstream stage of `isp_pipeline`, in the pixel clock domain. Consumes the YUYV pixel stream from `yuv_data_o`/`yuv_data_valid_o` at 1, 2 or 4 pixels per clock and repacks it into dense 64-bit words (4 pixels). Words go out on a ready/valid interface for the frame-buffer DMA writer. The block buffers output words in a small FIFO, tags the final word of each frame, flushes partial words at frame end, and reports sticky error flags.

---
 rtl/isp_pkg.sv | 32 +++
 rtl/sync_word_fifo.sv | 52 +++++
 rtl/yuv_word_packer.sv | 150 +++++++++++++++
 tb/tb_yuv_word_packer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared types for the ISP output stage: packer FSM states, the packed FIFO word
// and the legal pixel-valid patterns.
package isp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      FLUSH_PEND,
      FLUSH_PART
   } packer_state_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } packed_word_t;

   localparam logic [3:0] VALID_1PPC = 4'b0001;
   localparam logic [3:0] VALID_2PPC = 4'b0011;
   localparam logic [3:0] VALID_4PPC = 4'b1111;

   // Pixel count of a legal pattern; 0 for idle or illegal patterns.
   function automatic logic [2:0] pattern_pixels(input logic [3:0] pat);
      case (pat)
         VALID_1PPC: pattern_pixels = 3'd1;
         VALID_2PPC: pattern_pixels = 3'd2;
         VALID_4PPC: pattern_pixels = 3'd4;
         default:    pattern_pixels = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock FIFO of packed words with first-word-fall-through head output.
// A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
module sync_word_fifo
   import isp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         push_i,
   input  packed_word_t push_word_i,
   input  logic         pop_i,
   output packed_word_t head_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int AW = $clog2(DEPTH);

   packed_word_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW + 1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_word_i;
      end
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
   end

endmodule

// File: rtl/yuv_word_packer.sv
// Repacks a 1/2/4 pixel-per-clock YUYV stream into 64-bit four-pixel words,
// flushing a partial word at frame end and queueing words for the DMA writer.
module yuv_word_packer
   import isp_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        pixel_clk_i,
   input  logic        reset_i,
   input  logic        frame_valid_i,
   input  logic [63:0] yuv_data_i,
   input  logic [3:0]  yuv_data_valid_i,
   output logic [63:0] word_data_o,
   output logic [7:0]  word_strb_o,
   output logic        word_last_o,
   output logic        word_valid_o,
   input  logic        word_ready_i,
   input  logic        clear_err_i,
   output logic [2:0]  err_o,
   output logic [15:0] frame_count_o
);

   packer_state_t state_q;
   logic [1:0]    n_q, n_d;
   logic [47:0]   acc_q, acc_d;
   logic          pend_valid_q, pend_valid_d;
   logic [63:0]   pend_data_q, pend_data_d;
   logic [2:0]    err_q, err_d;
   logic [15:0]   frame_count_q;

   logic [63:0]   masked_in;
   logic [111:0]  merged;
   logic [2:0]    k;
   logic [2:0]    total;
   logic          in_frame_state;
   logic          accept;
   logic          push;
   packed_word_t  push_word;
   packed_word_t  head;
   logic          fifo_empty;
   logic          fifo_full;
   logic          overflow;

   // Unused input lanes are zeroed so accumulator bits above n pixels stay clear.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign masked_in[16*gi +: 16] = yuv_data_valid_i[gi] ? yuv_data_i[16*gi +: 16] : 16'd0;
   end

   assign k              = pattern_pixels(yuv_data_valid_i);
   assign total          = {1'b0, n_q} + k;
   assign in_frame_state = (state_q == IDLE) || (state_q == ACTIVE);
   assign accept         = frame_valid_i && in_frame_state && (k != 3'd0);
   assign merged         = ({48'd0, masked_in} << {n_q, 4'b0000}) | {64'd0, acc_q};
   assign overflow       = push && fifo_full && !(word_valid_o && word_ready_i);

   always_comb begin
      n_d          = n_q;
      acc_d        = acc_q;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      push         = 1'b0;
      push_word    = '0;
      if (accept) begin
         if (total >= 3'd4) begin
            push         = pend_valid_q;
            push_word    = '{data: pend_data_q, strb: 8'hFF, last: 1'b0};
            pend_valid_d = 1'b1;
            pend_data_d  = merged[63:0];
            acc_d        = merged[111:64];
            n_d          = 2'(total - 3'd4);
         end else begin
            acc_d = merged[47:0];
            n_d   = total[1:0];
         end
      end
      case (state_q)
         FLUSH_PEND: begin
            push         = pend_valid_q;
            push_word    = '{data: pend_data_q, strb: 8'hFF, last: (n_q == 2'd0)};
            pend_valid_d = 1'b0;
         end
         FLUSH_PART: begin
            push           = (n_q != 2'd0);
            push_word.data = {16'd0, acc_q};
            push_word.last = 1'b1;
            case (n_q)
               2'd1:    push_word.strb = 8'h03;
               2'd2:    push_word.strb = 8'h0F;
               2'd3:    push_word.strb = 8'h3F;
               default: push_word.strb = 8'h00;
            endcase
            n_d   = 2'd0;
            acc_d = '0;
         end
         default: ;
      endcase
      // A new error event outranks a coincident clear.
      err_d = (clear_err_i ? 3'b000 : err_q)
            | {(yuv_data_valid_i != 4'd0) && !(frame_valid_i && in_frame_state),
               (yuv_data_valid_i != 4'd0) && (k == 3'd0),
               overflow};
   end

   always_ff @(posedge pixel_clk_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         n_q           <= 2'd0;
         acc_q         <= '0;
         pend_valid_q  <= 1'b0;
         pend_data_q   <= '0;
         err_q         <= 3'b000;
         frame_count_q <= 16'd0;
      end else begin
         n_q          <= n_d;
         acc_q        <= acc_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         err_q        <= err_d;
         case (state_q)
            IDLE:       if (frame_valid_i) state_q <= ACTIVE;
            ACTIVE:     if (!frame_valid_i) state_q <= FLUSH_PEND;
            FLUSH_PEND: state_q <= FLUSH_PART;
            FLUSH_PART: begin
               state_q       <= IDLE;
               frame_count_q <= frame_count_q + 16'd1;
            end
            default:    state_q <= IDLE;
         endcase
      end
   end

   sync_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i       (pixel_clk_i),
      .reset_i     (reset_i),
      .push_i      (push),
      .push_word_i (push_word),
      .pop_i       (word_ready_i),
      .head_o      (head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   assign word_valid_o  = !fifo_empty;
   assign word_data_o   = fifo_empty ? 64'd0 : head.data;
   assign word_strb_o   = fifo_empty ? 8'd0 : head.strb;
   assign word_last_o   = fifo_empty ? 1'b0 : head.last;
   assign err_o         = err_q;
   assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_yuv_word_packer.sv
// Self-checking bench for yuv_word_packer: table of frames plus hand sequences
// for flush timing, errors, overflow and mid-frame reset; words scored from a queue.
module tb_yuv_word_packer;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        frame_valid_i;
   logic [63:0] yuv_data_i;
   logic [3:0]  yuv_data_valid_i;
   logic [63:0] word_data_o;
   logic [7:0]  word_strb_o;
   logic        word_last_o;
   logic        word_valid_o;
   logic        word_ready_i;
   logic        clear_err_i;
   logic [2:0]  err_o;
   logic [15:0] frame_count_o;

   always #5 clk = ~clk;

   yuv_word_packer #(.FIFO_DEPTH(8)) dut (
      .pixel_clk_i      (clk),
      .reset_i          (reset_i),
      .frame_valid_i    (frame_valid_i),
      .yuv_data_i       (yuv_data_i),
      .yuv_data_valid_i (yuv_data_valid_i),
      .word_data_o      (word_data_o),
      .word_strb_o      (word_strb_o),
      .word_last_o      (word_last_o),
      .word_valid_o     (word_valid_o),
      .word_ready_i     (word_ready_i),
      .clear_err_i      (clear_err_i),
      .err_o            (err_o),
      .frame_count_o    (frame_count_o)
   );

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } exp_word_t;

   typedef struct {
      logic [3:0] pat;
      int         cycles;
      int         exp_words;
      logic [7:0] exp_last_strb;
   } frame_vec_t;

   exp_word_t   sb_q[$];
   exp_word_t   mon_e;
   logic [15:0] frame_px[$];
   logic [15:0] pixval = 16'd0;
   logic [15:0] exp_fc = 16'd0;
   int          total = 0;
   int          bad = 0;
   int          delivered = 0;
   logic [7:0]  last_strb_seen;
   logic [63:0] first_word_seen;
   frame_vec_t  vec[7];

   // Scoreboard: every handshake pops one expected word.
   always @(negedge clk) begin
      if (!reset_i && word_valid_o && word_ready_i) begin
         total++;
         $display("word data=%h strb=%h last=%b", word_data_o, word_strb_o, word_last_o);
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word actual=%h/%h/%b required=none",
                     word_data_o, word_strb_o, word_last_o);
         end else begin
            mon_e = sb_q.pop_front();
            if (word_data_o !== mon_e.data || word_strb_o !== mon_e.strb ||
                word_last_o !== mon_e.last) begin
               bad++;
               $display("FAIL word actual=%h/%h/%b required=%h/%h/%b",
                        word_data_o, word_strb_o, word_last_o,
                        mon_e.data, mon_e.strb, mon_e.last);
            end
         end
         if (delivered == 0) first_word_seen = word_data_o;
         delivered++;
         last_strb_seen = word_strb_o;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive(input logic fv, input logic [3:0] pat, input logic take);
      frame_valid_i    = fv;
      yuv_data_valid_i = pat;
      for (int l = 0; l < 4; l++) begin
         if (pat[l]) begin
            yuv_data_i[16*l +: 16] = pixval;
            if (take) frame_px.push_back(pixval);
            pixval++;
         end else begin
            yuv_data_i[16*l +: 16] = 16'($urandom);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic end_frame();
      for (int i = 0; i < 3; i++) drive(1'b0, 4'b0000, 1'b0);
      exp_fc++;
      check("frame_count", 64'(frame_count_o), 64'(exp_fc));
   endtask

   task automatic expect_frame(input int max_words);
      int n = frame_px.size();
      int w = 0;
      for (int i = 0; i < n; i += 4) begin
         exp_word_t e;
         e.data = '0;
         e.strb = '0;
         for (int j = 0; j < 4; j++) begin
            if (i + j < n) begin
               e.data[16*j +: 16] = frame_px[i+j];
               e.strb[2*j +: 2]   = 2'b11;
            end
         end
         e.last = (i + 4 >= n);
         if (w < max_words) sb_q.push_back(e);
         w++;
      end
      frame_px.delete();
   endtask

   task automatic drain();
      int guard = 0;
      word_ready_i = 1'b1;
      while (sb_q.size() != 0 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("empty_after_drain", 64'(word_valid_o), 64'd0);
      word_ready_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = '{4'b1111, 8, 8, 8'hFF};
      vec[1] = '{4'b0001, 6, 2, 8'h0F};
      vec[2] = '{4'b0011, 3, 2, 8'h0F};
      vec[3] = '{4'b0001, 7, 2, 8'h3F};
      vec[4] = '{4'b0001, 5, 2, 8'h03};
      vec[5] = '{4'b0011, 4, 2, 8'hFF};
      vec[6] = '{4'b0000, 3, 0, 8'h00};

      reset_i          = 1'b1;
      frame_valid_i    = 1'b0;
      yuv_data_i       = '0;
      yuv_data_valid_i = 4'b0000;
      word_ready_i     = 1'b0;
      clear_err_i      = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset_i = 1'b0;
      @(posedge clk);
      #1;
      check("rst_valid", 64'(word_valid_o), 64'd0);
      check("rst_data", word_data_o, 64'd0);
      check("rst_strb", 64'(word_strb_o), 64'd0);
      check("rst_last", 64'(word_last_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
      check("rst_fc", 64'(frame_count_o), 64'd0);

      // Table of whole frames at a constant pattern.
      for (int r = 0; r < 7; r++) begin
         delivered = 0;
         for (int c = 0; c < vec[r].cycles; c++) drive(1'b1, vec[r].pat, 1'b1);
         end_frame();
         expect_frame(1000);
         drain();
         check($sformatf("row%0d_words", r), 64'(delivered), 64'(vec[r].exp_words));
         if (vec[r].exp_words > 0)
            check($sformatf("row%0d_last_strb", r), 64'(last_strb_seen), 64'(vec[r].exp_last_strb));
         if (r == 0)
            check("row0_first_word", first_word_seen, 64'h0003_0002_0001_0000);
      end

      // Mixed 2ppc/4ppc frame with flush timing.
      delivered = 0;
      drive(1'b1, 4'b0011, 1'b1);
      drive(1'b1, 4'b1111, 1'b1);
      drive(1'b0, 4'b0000, 1'b0);
      check("mixed_valid_f1", 64'(word_valid_o), 64'd0);
      drive(1'b0, 4'b0000, 1'b0);
      check("mixed_valid_f2", 64'(word_valid_o), 64'd1);
      drive(1'b0, 4'b0000, 1'b0);
      exp_fc++;
      check("mixed_fc", 64'(frame_count_o), 64'(exp_fc));
      expect_frame(1000);
      drain();
      check("mixed_words", 64'(delivered), 64'd2);
      check("mixed_last_strb", 64'(last_strb_seen), 64'h0F);

      // Illegal pattern inside a frame.
      delivered = 0;
      drive(1'b1, 4'b0001, 1'b1);
      drive(1'b1, 4'b0101, 1'b0);
      check("err_illegal", 64'(err_o), 64'b010);
      for (int i = 0; i < 3; i++) drive(1'b1, 4'b0001, 1'b1);
      end_frame();
      expect_frame(1000);
      drain();
      check("illegal_words", 64'(delivered), 64'd1);
      clear_err_i = 1'b1;
      drive(1'b0, 4'b0000, 1'b0);
      clear_err_i = 1'b0;
      check("err_clear1", 64'(err_o), 64'd0);
      drive(1'b0, 4'b1111, 1'b0);
      check("err_outside", 64'(err_o), 64'b100);
      clear_err_i = 1'b1;
      drive(1'b0, 4'b0011, 1'b0);
      clear_err_i = 1'b0;
      check("err_wins_clear", 64'(err_o), 64'b100);
      clear_err_i = 1'b1;
      drive(1'b0, 4'b0000, 1'b0);
      clear_err_i = 1'b0;
      check("err_clear2", 64'(err_o), 64'd0);

      // Overflow: ten words into an eight-entry FIFO with the consumer stalled.
      delivered = 0;
      for (int i = 0; i < 10; i++) drive(1'b1, 4'b1111, 1'b1);
      end_frame();
      check("err_overflow", 64'(err_o), 64'b001);
      expect_frame(8);
      drain();
      check("overflow_words", 64'(delivered), 64'd8);
      clear_err_i = 1'b1;
      drive(1'b0, 4'b0000, 1'b0);
      clear_err_i = 1'b0;
      check("err_clear3", 64'(err_o), 64'd0);

      // Reset mid-frame with three words queued; the frame resumes as a new one.
      delivered = 0;
      for (int i = 0; i < 4; i++) drive(1'b1, 4'b1111, 1'b1);
      drive(1'b1, 4'b0101, 1'b0);
      reset_i = 1'b1;
      frame_px.delete();
      drive(1'b1, 4'b0000, 1'b0);
      reset_i = 1'b0;
      exp_fc = 16'd0;
      check("mrst_valid", 64'(word_valid_o), 64'd0);
      check("mrst_err", 64'(err_o), 64'd0);
      check("mrst_fc", 64'(frame_count_o), 64'd0);
      for (int i = 0; i < 2; i++) drive(1'b1, 4'b1111, 1'b1);
      end_frame();
      expect_frame(1000);
      drain();
      check("mrst_words", 64'(delivered), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
